add_round_key_seq: RTL

- Parametrised, handshaked AddRoundKey engine for the AES round datapath.
- Captures one state block and one round key, then XORs them LANE_WORDS words per clock over several beats.
- Presents the result through a valid/ready output with backpressure.
- Sits between the MixColumns stage and the next-round SubBytes stage; also serves the initial round-0 key add.

---
 rtl/add_round_key_seq_if.sv | 61 ++++++
 rtl/add_round_key_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_seq_if.sv
// ---------------------------------------------------------------------------
// add_round_key_seq_if
//
// Purpose: bundles the handshake and data buses of the AddRoundKey engine so
// that a producer/consumer pair can be hooked up with a single connection.
//
// Parameters:
//   word_size   bits per state word (byte)
//   array_size  words per block; block width is word_size*array_size
//
// Signals:
//   in_valid   producer offers key/state
//   in_ready   engine can accept a new block
//   key        round key, word i = key[i*word_size +: word_size]
//   state      state block, same word packing as key
//   out_valid  state_out holds a finished result
//   out_ready  consumer accepts the result
//   state_out  key XOR state
//   busy       engine is processing or holding a result
//   par_out    per-word even parity of state_out (only with ARK_PARITY_EN)
//
// Modports:
//   master  producer/consumer side (drives inputs, observes results)
//   slave   engine side
//
// Optional feature macro: ARK_PARITY_EN
// ---------------------------------------------------------------------------
interface add_round_key_seq_if #(
   parameter int word_size  = 8,
   parameter int array_size = 16
);

   logic                              in_valid;
   logic                              in_ready;
   logic [word_size*array_size-1:0]   key;
   logic [word_size*array_size-1:0]   state;
   logic                              out_valid;
   logic                              out_ready;
   logic [word_size*array_size-1:0]   state_out;
   logic                              busy;
`ifdef ARK_PARITY_EN
   logic [array_size-1:0]             par_out;
`endif

   modport master (
      output in_valid, key, state, out_ready,
      input  in_ready, out_valid, state_out, busy
`ifdef ARK_PARITY_EN
      , input par_out
`endif
   );

   modport slave (
      input  in_valid, key, state, out_ready,
      output in_ready, out_valid, state_out, busy
`ifdef ARK_PARITY_EN
      , output par_out
`endif
   );

endinterface

// File: rtl/add_round_key_seq.sv
// ---------------------------------------------------------------------------
// add_round_key_seq
//
// Purpose: handshaked AddRoundKey engine for the AES round datapath. A key
// and a state block are captured together, then XORed LANE_WORDS words per
// clock (lowest words first) into state_out. The finished block is offered
// on a valid/ready output and held until the consumer takes it. Used between
// MixColumns and the next round's SubBytes, and for the initial key add.
//
// Parameters:
//   word_size   bits per state word (default 8)
//   array_size  words per block (default 16)
//   LANE_WORDS  words XORed per clock; must divide array_size exactly
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   add_round_key_seq_if.slave:
//           in_valid/in_ready/key/state      input handshake and data
//           out_valid/out_ready/state_out    output handshake and data
//           busy                             high while RUN or OUT
//           par_out                          per-word parity (optional)
//
// Optional feature macro: ARK_PARITY_EN
//   When defined, par_out[i] carries the even parity (XOR reduction) of
//   state_out word i, registered together with each lane write.
// ---------------------------------------------------------------------------
module add_round_key_seq #(
   parameter int word_size  = 8,
   parameter int array_size = 16,
   parameter int LANE_WORDS = 4
) (
   input logic               clk,
   input logic               rst,
   add_round_key_seq_if.slave bus
);

   localparam int BLOCK_BITS = word_size * array_size;
   localparam int LANE_BITS  = word_size * LANE_WORDS;
   localparam int NUM_BEATS  = array_size / LANE_WORDS;
   localparam int CNT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   // A lane width that does not tile the block would leave words unwritten,
   // so refuse to elaborate such a configuration.
   generate
      if ((array_size % LANE_WORDS) != 0) begin : g_bad_lane
         $error("add_round_key_seq: LANE_WORDS must divide array_size exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_OUT
   } fsm_t;

   fsm_t                    cur_state;
   fsm_t                    next_state;
   logic                    capture;
   logic                    lane_we;
   logic [CNT_W-1:0]        cnt;
   logic [BLOCK_BITS-1:0]   key_reg;
   logic [BLOCK_BITS-1:0]   state_reg;
   logic [BLOCK_BITS-1:0]   block_xor;
   logic [BLOCK_BITS-1:0]   state_out_reg;

   // State register. Reset lands in IDLE straight away so that an aborted
   // block never produces an out_valid pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= next_state;
      end
   end

   // Next-state and control decode. IDLE accepts a block, RUN writes one
   // lane per clock until the last beat, OUT waits for the consumer. Leaving
   // OUT always passes through IDLE, so a new block is never accepted on the
   // same edge that drains the previous result.
   always_comb begin
      next_state = cur_state;
      capture    = 1'b0;
      lane_we    = 1'b0;
      case (cur_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               capture    = 1'b1;
               next_state = S_RUN;
            end
         end
         S_RUN: begin
            lane_we = 1'b1;
            if (cnt == LAST_BEAT) begin
               next_state = S_OUT;
            end
         end
         S_OUT: begin
            if (bus.out_ready) begin
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Beat counter selecting which lane is written this clock. It stops on
   // the last beat; the next capture clears it for the following block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (capture) begin
         cnt <= '0;
      end else if (lane_we && (cnt != LAST_BEAT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Key and state are copied at the accepting edge so the producer is free
   // to change its buses while the block is still being processed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_reg   <= '0;
         state_reg <= '0;
      end else if (capture) begin
         key_reg   <= bus.key;
         state_reg <= bus.state;
      end
   end

   // The XOR is bitwise with no carries, so the full-width result can be
   // formed once and the lanes simply picked out of it beat by beat.
   assign block_xor = key_reg ^ state_reg;

   // Lane write-back. Only the lane addressed by cnt changes; every other
   // word keeps its previous contents, which is why partially updated
   // results are visible during RUN and why consumers must qualify with
   // out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_out_reg <= '0;
      end else if (lane_we) begin
         for (int l = 0; l < NUM_BEATS; l++) begin
            if (cnt == CNT_W'(l)) begin
               state_out_reg[l*LANE_BITS +: LANE_BITS] <= block_xor[l*LANE_BITS +: LANE_BITS];
            end
         end
      end
   end

`ifdef ARK_PARITY_EN
   logic [array_size-1:0] word_par;
   logic [array_size-1:0] par_reg;

   // Parity of every word of the finished block, taken from the same XOR
   // value that is about to be written into state_out.
   always_comb begin
      word_par = '0;
      for (int w = 0; w < array_size; w++) begin
         word_par[w] = ^block_xor[w*word_size +: word_size];
      end
   end

   // Parity bits follow their words: they are updated with the same lane
   // write so they match state_out whenever out_valid is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_reg <= '0;
      end else if (lane_we) begin
         for (int l = 0; l < NUM_BEATS; l++) begin
            if (cnt == CNT_W'(l)) begin
               par_reg[l*LANE_WORDS +: LANE_WORDS] <= word_par[l*LANE_WORDS +: LANE_WORDS];
            end
         end
      end
   end

   assign bus.par_out = par_reg;
`endif

   // Handshake outputs decode directly from the state register, so an
   // asynchronous reset clears busy and out_valid without waiting for a
   // clock. in_ready stays low while reset itself is held.
   assign bus.in_ready  = (cur_state == S_IDLE) && !rst;
   assign bus.out_valid = (cur_state == S_OUT);
   assign bus.busy      = (cur_state == S_RUN) || (cur_state == S_OUT);
   assign bus.state_out = state_out_reg;

endmodule
